control_subcmd_fillpattern: RTL

Parametrised successor to the solid-fill sub-command. It writes a clipped rectangle of the frame buffer with one of four patterns built from two colors: solid, checkerboard, row stripes or column stripes. It tolerates RAM back-pressure through a ready input. It sits under the control command decoder beside the other `control_subcmd_*` blocks and drives the shared row/column/pixel RAM write port.

---
 rtl/control_subcmd_fillpattern_pkg.sv | 24 ++
 rtl/control_subcmd_fillpattern_addr_gen.sv | 66 ++++++
 rtl/control_subcmd_fillpattern.sv | 131 +++++++++++++
 3 files changed

// File: rtl/control_subcmd_fillpattern_pkg.sv
// control_subcmd_fillpattern_pkg: shared types and defaults for the pattern-fill sub-command.
//   BYTES_PER_PIXEL      default bytes written per frame-buffer pixel
//   fillpattern_mode_t   pattern select encoding seen on the mode input
//   fillpattern_state_t  sequencer states of the fill engine
package control_subcmd_fillpattern_pkg;

   localparam int BYTES_PER_PIXEL = 2;

   typedef enum logic [1:0] {
      SOLID,
      CHECKER,
      ROWSTRIPE,
      COLSTRIPE
   } fillpattern_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_WRITE,
      ST_DONE,
      ST_WAIT_RELEASE
   } fillpattern_state_t;

endpackage

// File: rtl/control_subcmd_fillpattern_addr_gen.sv
// control_subcmd_fillpattern_addr_gen: row/column/byte scan counter over a clipped rectangle.
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_load                 capture bounds and start at (y_hi, x_lo, byte 0)
//   i_advance              step to the next byte of the scan
//   i_x_lo, i_x_hi         inclusive column bounds
//   i_y_lo, i_y_hi         inclusive row bounds (scan starts at y_hi and descends)
//   o_row, o_column, o_pixel  current write address
//   o_last                 current address is the final byte of the rectangle
module control_subcmd_fillpattern_addr_gen #(
   parameter int CW  = 6,
   parameter int RW  = 5,
   parameter int PW  = 1,
   parameter int BPP = 2
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_load,
   input  logic          i_advance,
   input  logic [CW-1:0] i_x_lo,
   input  logic [CW-1:0] i_x_hi,
   input  logic [RW-1:0] i_y_lo,
   input  logic [RW-1:0] i_y_hi,
   output logic [RW-1:0] o_row,
   output logic [CW-1:0] o_column,
   output logic [PW-1:0] o_pixel,
   output logic          o_last
);

   localparam logic [PW-1:0] PIX_LAST = PW'(BPP - 1);

   logic [CW-1:0] r_x_lo, r_x_hi, r_column;
   logic [RW-1:0] r_y_lo, r_row;
   logic [PW-1:0] r_pixel;
   logic          w_pix_wrap, w_col_wrap;

   assign w_pix_wrap = r_pixel == PIX_LAST;
   assign w_col_wrap = r_column == r_x_hi;
   assign o_last     = w_pix_wrap & w_col_wrap & (r_row == r_y_lo);
   assign o_row      = r_row;
   assign o_column   = r_column;
   assign o_pixel    = r_pixel;

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         r_x_lo   <= '0;
         r_x_hi   <= '0;
         r_y_lo   <= '0;
         r_row    <= '0;
         r_column <= '0;
         r_pixel  <= '0;
      end else if (i_load) begin
         r_x_lo   <= i_x_lo;
         r_x_hi   <= i_x_hi;
         r_y_lo   <= i_y_lo;
         r_row    <= i_y_hi;
         r_column <= i_x_lo;
         r_pixel  <= '0;
      end else if (i_advance) begin
         r_pixel <= w_pix_wrap ? '0 : r_pixel + PW'(1);
         if (w_pix_wrap) begin
            r_column <= w_col_wrap ? r_x_lo : r_column + CW'(1);
            if (w_col_wrap) r_row <= r_row - RW'(1);
         end
      end

endmodule

// File: rtl/control_subcmd_fillpattern.sv
// control_subcmd_fillpattern: fills a clipped frame-buffer rectangle with a two-color pattern.
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_enable                  command request, held high for the whole command
//   i_ack                     decoder acknowledges o_done
//   i_ram_ready               RAM accepts a write this cycle
//   i_mode                    0 solid, 1 checker, 2 row stripes, 3 column stripes
//   i_x1, i_y1                top-left corner
//   i_width, i_height         rectangle size, zero allowed
//   i_color_a, i_color_b      pattern colors
//   o_row, o_column, o_pixel  RAM write address
//   o_data_out                RAM write byte
//   o_ram_write_enable        write commits at this clock edge
//   o_ram_access_start        one-cycle pulse when a fill starts
//   o_done                    fill complete, held until acknowledged
module control_subcmd_fillpattern #(
   parameter int  PIXEL_WIDTH     = 64,
   parameter int  PIXEL_HEIGHT    = 32,
   parameter int  BYTES_PER_PIXEL = control_subcmd_fillpattern_pkg::BYTES_PER_PIXEL,
   localparam int CW = $clog2(PIXEL_WIDTH),
   localparam int RW = $clog2(PIXEL_HEIGHT),
   localparam int PW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
   localparam int DW = 8 * BYTES_PER_PIXEL
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_enable,
   input  logic          i_ack,
   input  logic          i_ram_ready,
   input  logic [1:0]    i_mode,
   input  logic [CW-1:0] i_x1,
   input  logic [RW-1:0] i_y1,
   input  logic [CW:0]   i_width,
   input  logic [RW:0]   i_height,
   input  logic [DW-1:0] i_color_a,
   input  logic [DW-1:0] i_color_b,
   output logic [RW-1:0] o_row,
   output logic [CW-1:0] o_column,
   output logic [PW-1:0] o_pixel,
   output logic [7:0]    o_data_out,
   output logic          o_ram_write_enable,
   output logic          o_ram_access_start,
   output logic          o_done
);

   import control_subcmd_fillpattern_pkg::*;

   localparam logic [CW+1:0] X_LIM = (CW+2)'(PIXEL_WIDTH);
   localparam logic [RW+1:0] Y_LIM = (RW+2)'(PIXEL_HEIGHT);

   fillpattern_state_t r_state;
   fillpattern_mode_t  r_mode;
   logic [DW-1:0]      r_color_a, r_color_b, w_color;
   logic [CW+1:0]      w_x_sum, w_x_clip;
   logic [RW+1:0]      w_y_sum, w_y_clip;
   logic [CW-1:0]      w_x_hi, w_column;
   logic [RW-1:0]      w_y_hi, w_row;
   logic [PW-1:0]      w_pixel;
   logic               w_empty, w_we, w_last, w_sel;

   // Two guard bits keep corner+size and the clip compare from wrapping.
   assign w_x_sum  = {2'b00, i_x1} + {1'b0, i_width};
   assign w_y_sum  = {2'b00, i_y1} + {1'b0, i_height};
   assign w_x_clip = (w_x_sum > X_LIM) ? X_LIM : w_x_sum;
   assign w_y_clip = (w_y_sum > Y_LIM) ? Y_LIM : w_y_sum;
   assign w_x_hi   = CW'(w_x_clip - (CW+2)'(1));
   assign w_y_hi   = RW'(w_y_clip - (RW+2)'(1));
   assign w_empty  = (i_width == '0) | (i_height == '0) |
                     ({2'b00, i_x1} >= X_LIM) | ({2'b00, i_y1} >= Y_LIM);

   assign w_we               = (r_state == ST_WRITE) & i_ram_ready;
   assign o_ram_write_enable = w_we;
   assign o_ram_access_start = r_state == ST_LATCH;
   assign o_done             = r_state == ST_DONE;

   // The counter parks on the final byte so the address stays meaningful after the fill.
   control_subcmd_fillpattern_addr_gen #(
      .CW (CW),
      .RW (RW),
      .PW (PW),
      .BPP(BYTES_PER_PIXEL)
   ) u_addr_gen (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_load   (r_state == ST_LATCH),
      .i_advance(w_we & ~w_last),
      .i_x_lo   (i_x1),
      .i_x_hi   (w_x_hi),
      .i_y_lo   (i_y1),
      .i_y_hi   (w_y_hi),
      .o_row    (w_row),
      .o_column (w_column),
      .o_pixel  (w_pixel),
      .o_last   (w_last)
   );

   assign o_row    = w_row;
   assign o_column = w_column;
   assign o_pixel  = w_pixel;

   assign w_sel = (r_mode == CHECKER)   ? w_row[0] ^ w_column[0] :
                  (r_mode == ROWSTRIPE) ? w_row[0] :
                  (r_mode == COLSTRIPE) ? w_column[0] : 1'b0;
   assign w_color    = w_sel ? r_color_b : r_color_a;
   assign o_data_out = w_color[{w_pixel, 3'b000} +: 8];

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_mode    <= SOLID;
         r_color_a <= '0;
         r_color_b <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (i_enable) r_state <= ST_LATCH;
            ST_LATCH: begin
               r_mode    <= fillpattern_mode_t'(i_mode);
               r_color_a <= i_color_a;
               r_color_b <= i_color_b;
               r_state   <= !i_enable ? ST_IDLE : w_empty ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
               if (!i_enable) r_state <= ST_IDLE;
               else if (w_we & w_last) r_state <= ST_DONE;
            end
            ST_DONE: if (i_ack) r_state <= ST_WAIT_RELEASE;
            ST_WAIT_RELEASE: if (!i_enable) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end

endmodule
